// File: rtl/layer_output_serializer_pkg.sv
// Shared definitions for the layer output serializer.
//   state_t   : FSM encoding (ST_IDLE waits for a full group, ST_SHIFT replays it)
//   idx_width : width of the lane index for a given lane count (at least 1 bit)
package mlp_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    function automatic int idx_width(input int nn);
        return (nn > 1) ? $clog2(nn) : 1;
    endfunction

endpackage

// File: rtl/layer_output_serializer_if.sv
// Bus between a parallel neuron layer and the serializer, plus the serial
// output toward the next layer.
//   i_valid/i_data : per-lane result pulses, lane i at [i*dataWidth +: dataWidth]
//   i_clr_ovf      : clears the sticky overflow flag
//   o_valid/o_data : serial word stream, o_index = lane number, o_last on lane NN-1
//   busy/overflow  : status
//   fsm_state      : current FSM state, for observation only
// Handshake: valid-only, no ready. A lane result is taken on every rising edge
// where its i_valid bit is high; the receiver of o_data must take a word on
// every edge where o_valid is high.
interface layer_output_serializer_if
    import mlp_pkg::*;
#(
    parameter int NN        = 10,
    parameter int dataWidth = 16
);
    localparam int IDX_W = idx_width(NN);

    logic [NN-1:0]           i_valid;
    logic [NN*dataWidth-1:0] i_data;
    logic                    i_clr_ovf;
    logic                    o_valid;
    logic [dataWidth-1:0]    o_data;
    logic [IDX_W-1:0]        o_index;
    logic                    o_last;
    logic                    busy;
    logic                    overflow;
    state_t                  fsm_state;

    modport master (
        output i_valid, i_data, i_clr_ovf,
        input  o_valid, o_data, o_index, o_last, busy, overflow, fsm_state
    );

    modport slave (
        input  i_valid, i_data, i_clr_ovf,
        output o_valid, o_data, o_index, o_last, busy, overflow, fsm_state
    );

endinterface

// File: rtl/layer_output_serializer_collect.sv
// Collect buffer: gathers one group of NN lane results arriving in any order.
//   lane_valid/lane_data : raw lane pulses and data
//   load                 : the group is handed to the shift buffer on this edge
//   complete             : every lane is present once this edge's lanes are counted
//   pending              : a full group is parked, waiting for the shifter
//   dup_hit / drop_hit   : a lane was overwritten / a lane was dropped while parked
//   coll_next            : buffer contents including lanes captured on this edge
module layer_output_serializer_collect #(
    parameter int NN        = 10,
    parameter int dataWidth = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NN-1:0]           lane_valid,
    input  logic [NN*dataWidth-1:0] lane_data,
    input  logic                    load,
    output logic                    complete,
    output logic                    pending,
    output logic                    dup_hit,
    output logic                    drop_hit,
    output logic [NN*dataWidth-1:0] coll_next
);
    logic [NN-1:0]           got;
    logic [NN-1:0]           accept;
    logic [NN-1:0]           got_next;
    logic [NN*dataWidth-1:0] coll;
    logic                    pend;

    // A parked group is frozen: nothing new is accepted until it is loaded.
    assign accept   = lane_valid & {NN{~pend}};
    assign got_next = got | accept;
    assign complete = ~pend & (&got_next);
    assign dup_hit  = |(accept & got);
    assign drop_hit = pend & (|lane_valid);
    assign pending  = pend;

    always_comb begin
        coll_next = coll;
        for (int i = 0; i < NN; i++) begin
            if (accept[i]) begin
                coll_next[i*dataWidth +: dataWidth] = lane_data[i*dataWidth +: dataWidth];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            got  <= '0;
            coll <= '0;
            pend <= 1'b0;
        end else begin
            coll <= coll_next;
            if (load) begin
                got  <= '0;
                pend <= 1'b0;
            end else if (complete) begin
                // got stays all ones so the parked group blocks new lanes.
                got  <= '1;
                pend <= 1'b1;
            end else begin
                got  <= got_next;
            end
        end
    end

endmodule

// File: rtl/layer_output_serializer.sv
// Layer output serializer: turns a group of NN parallel neuron results into a
// serial word stream, one word per cycle, lane 0 first.
//   clk, rst : rising-edge clock, asynchronous active-low reset
//   bus      : lane inputs, serial output and status (slave side)
// A second group can complete while the first is shifting; it is loaded on
// the last beat so consecutive streams have no bubble.
module layer_output_serializer
    import mlp_pkg::*;
#(
    parameter int NN        = 10,
    parameter int dataWidth = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    layer_output_serializer_if.slave bus
);
    localparam int IDX_W = idx_width(NN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NN - 1);

    state_t                  state;
    state_t                  state_next;
    logic [IDX_W-1:0]        idx;
    logic [NN*dataWidth-1:0] sbuf;
    logic                    ovf;
    logic                    load;
    logic                    complete;
    logic                    pending;
    logic                    dup_hit;
    logic                    drop_hit;
    logic [NN*dataWidth-1:0] coll_next;

    layer_output_serializer_collect #(
        .NN        (NN),
        .dataWidth (dataWidth)
    ) u_collect (
        .clk        (clk),
        .rst        (rst),
        .lane_valid (bus.i_valid),
        .lane_data  (bus.i_data),
        .load       (load),
        .complete   (complete),
        .pending    (pending),
        .dup_hit    (dup_hit),
        .drop_hit   (drop_hit),
        .coll_next  (coll_next)
    );

    // State register plus the datapath registers it steers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            idx   <= '0;
            sbuf  <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_next;
            if (load) begin
                // coll_next already holds lanes arriving on this same edge.
                sbuf <= coll_next;
                idx  <= '0;
            end else if (state_next == ST_IDLE) begin
                idx  <= '0;
            end else begin
                idx  <= idx + 1'b1;
            end
            // A new loss on the same edge as a clear keeps the flag set.
            if (dup_hit || drop_hit) begin
                ovf <= 1'b1;
            end else if (bus.i_clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

    // Next state and the load decision.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (complete) begin
                    load       = 1'b1;
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (idx == LAST_IDX) begin
                    if (pending || complete) begin
                        load = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs are decoded from registers only.
    always_comb begin
        bus.o_valid   = (state == ST_SHIFT);
        bus.o_data    = '0;
        bus.o_index   = '0;
        bus.o_last    = 1'b0;
        if (state == ST_SHIFT) begin
            bus.o_data  = sbuf[idx*dataWidth +: dataWidth];
            bus.o_index = idx;
            bus.o_last  = (idx == LAST_IDX);
        end
        bus.busy      = (state == ST_SHIFT) | pending;
        bus.overflow  = ovf;
        bus.fsm_state = state;
    end

endmodule

// File: tb/tb_layer_output_serializer.sv
// Directed bench for layer_output_serializer (NN=10, dataWidth=16).
module tb_layer_output_serializer;
    import mlp_pkg::*;

    localparam int NN = 10;
    localparam int DW = 16;
    localparam int IW = idx_width(NN);
    localparam int W  = DW + IW + 1;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    logic [W-1:0]  exp_q[$];
    logic [DW-1:0] grp [NN];

    layer_output_serializer_if #(.NN(NN), .dataWidth(DW)) ifc ();

    layer_output_serializer #(.NN(NN), .dataWidth(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        ifc.i_valid   = '0;
        ifc.i_clr_ovf = 1'b0;
    endtask

    task automatic drive_lane(input int i, input logic [DW-1:0] d);
        ifc.i_valid[i]           = 1'b1;
        ifc.i_data[i*DW +: DW]   = d;
    endtask

    task automatic drive_all_except(input int skip);
        for (int i = 0; i < NN; i++) begin
            if (i != skip) drive_lane(i, grp[i]);
        end
    endtask

    task automatic push_group();
        for (int i = 0; i < NN; i++) begin
            exp_q.push_back({(i == NN - 1), IW'(i), grp[i]});
        end
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check(tag, exp_q.size(), 0);
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (rst && ifc.o_valid) begin
            check("beat_expected", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("beat", {ifc.o_last, ifc.o_index, ifc.o_data}, e);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        tests         = 0;
        fails         = 0;
        rst           = 1'b0;
        ifc.i_valid   = '0;
        ifc.i_data    = '0;
        ifc.i_clr_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_o_valid", ifc.o_valid, 0);
        check("rst_o_data", ifc.o_data, 0);
        check("rst_o_index", ifc.o_index, 0);
        check("rst_o_last", ifc.o_last, 0);
        check("rst_busy", ifc.busy, 0);
        check("rst_overflow", ifc.overflow, 0);
        check("rst_state", ifc.fsm_state, ST_IDLE);
        rst = 1'b1;
        tick();

        // 1. all lanes in one cycle
        for (int i = 0; i < NN; i++) grp[i] = DW'(16'h0100 + i);
        drive_all_except(-1);
        push_group();
        tick();
        check("t1_first_valid", ifc.o_valid, 1);
        check("t1_first_index", ifc.o_index, 0);
        drain("t1_drain", 20);
        check("t1_idle_valid", ifc.o_valid, 0);
        check("t1_idle_busy", ifc.busy, 0);

        // 2. lanes 9..0 on separate cycles
        for (int i = 0; i < NN; i++) grp[i] = DW'(16'h0200 + i);
        for (int i = NN - 1; i > 0; i--) begin
            drive_lane(i, grp[i]);
            tick();
            check("t2_no_early_valid", ifc.o_valid, 0);
        end
        drive_lane(0, grp[0]);
        push_group();
        tick();
        check("t2_start_valid", ifc.o_valid, 1);
        drain("t2_drain", 20);

        // 3. back-to-back groups, second completes at beat 4
        for (int i = 0; i < NN; i++) grp[i] = DW'(16'h0300 + i);
        drive_all_except(-1);
        push_group();
        tick();
        for (int c = 0; c < 2 * NN; c++) begin
            check("t3_contig_valid", ifc.o_valid, 1);
            check("t3_busy", ifc.busy, 1);
            if (c == 4) begin
                for (int i = 0; i < NN; i++) grp[i] = DW'(16'h0380 + i);
                drive_all_except(-1);
                push_group();
            end
            tick();
        end
        check("t3_end_valid", ifc.o_valid, 0);
        check("t3_end_busy", ifc.busy, 0);
        check("t3_overflow", ifc.overflow, 0);
        check("t3_queue", exp_q.size(), 0);

        // 4. lane pulse while a group is parked
        for (int i = 0; i < NN; i++) grp[i] = DW'(16'h0400 + i);
        drive_all_except(-1);
        push_group();
        tick();
        for (int i = 0; i < NN; i++) grp[i] = DW'(16'h0500 + i);
        drive_all_except(-1);
        push_group();
        tick();
        check("t4_pending_busy", ifc.busy, 1);
        check("t4_pre_overflow", ifc.overflow, 0);
        drive_lane(3, 16'hDEAD);
        tick();
        check("t4_overflow_set", ifc.overflow, 1);
        ifc.i_clr_ovf = 1'b1;
        tick();
        check("t4_overflow_clr", ifc.overflow, 0);
        drain("t4_drain", 40);

        // 5. duplicate lane, clear on the same edge loses to the set
        drive_lane(2, 16'h0011);
        tick();
        check("t5_no_ovf_first", ifc.overflow, 0);
        drive_lane(2, 16'h0022);
        ifc.i_clr_ovf = 1'b1;
        tick();
        check("t5_dup_overflow", ifc.overflow, 1);
        for (int i = 0; i < NN; i++) grp[i] = DW'(16'h0600 + i);
        grp[2] = 16'h0022;
        drive_all_except(2);
        push_group();
        tick();
        drain("t5_drain", 20);
        ifc.i_clr_ovf = 1'b1;
        tick();
        check("t5_overflow_clr", ifc.overflow, 0);

        // 6. asynchronous reset in the middle of a stream
        for (int i = 0; i < NN; i++) grp[i] = DW'(16'h0700 + i);
        drive_all_except(-1);
        push_group();
        tick();
        repeat (5) tick();
        check("t6_beat5_index", ifc.o_index, 5);
        #1;
        rst = 1'b0;
        #1;
        check("t6_rst_valid", ifc.o_valid, 0);
        check("t6_rst_busy", ifc.busy, 0);
        exp_q.delete();
        tick();
        tick();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("t6_no_resume", ifc.o_valid, 0);
        end
        for (int i = 0; i < NN; i++) grp[i] = DW'($urandom_range(0, 16'hFFFF));
        drive_all_except(-1);
        push_group();
        tick();
        check("t6_restart_index", ifc.o_index, 0);
        drain("t6_drain", 20);

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
